// File: rtl/xunit_sha2_round.sv
// SHA-2 compression round unit for 32-bit (SHA-224/256) and 64-bit (SHA-384/512) words.
// Runs ROUNDS rounds per start pulse and can optionally add the initial hash state at the end.
module xunit_sha2_round #(
   parameter int DATA_W = 32,
   parameter int ROUNDS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic [DATA_W-1:0] in4,
   input  logic [DATA_W-1:0] in5,
   input  logic [DATA_W-1:0] in6,
   input  logic [DATA_W-1:0] in7,
   input  logic [DATA_W-1:0] in8,
   input  logic [DATA_W-1:0] in9,
   input  logic [7:0]        delay0,
   input  logic              feedfwd0,
   output logic [DATA_W-1:0] out0,
   output logic [DATA_W-1:0] out1,
   output logic [DATA_W-1:0] out2,
   output logic [DATA_W-1:0] out3,
   output logic [DATA_W-1:0] out4,
   output logic [DATA_W-1:0] out5,
   output logic [DATA_W-1:0] out6,
   output logic [DATA_W-1:0] out7,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, WAIT, ROUND, FINAL} state_t;

   localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

   function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
      return (x >> n) | (x << (DATA_W - n));
   endfunction

   function automatic logic [DATA_W-1:0] bsig0(input logic [DATA_W-1:0] x);
      if (DATA_W == 64) return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
      else              return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [DATA_W-1:0] bsig1(input logic [DATA_W-1:0] x);
      if (DATA_W == 64) return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
      else              return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [DATA_W-1:0] ch(input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] f,
                                            input logic [DATA_W-1:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [DATA_W-1:0] maj(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   state_t            state_p0;
   logic [7:0]        dly_p0;
   logic [7:0]        rnd_p0;
   logic              ff_p0;
   logic              done_p0;
   logic [DATA_W-1:0] work_p0 [8];
   logic [DATA_W-1:0] hash_p0 [8];

   logic              first;
   logic [DATA_W-1:0] init [8];
   logic [DATA_W-1:0] opnd [8];
   logic [DATA_W-1:0] nxt  [8];
   logic [DATA_W-1:0] t1;
   logic [DATA_W-1:0] t2;

   // Round 0 takes its working state straight from the inputs so no load cycle is needed.
   always_comb begin
      first = (rnd_p0 == 8'd0);
      init  = '{in0, in1, in2, in3, in4, in5, in6, in7};
      for (int i = 0; i < 8; i++) opnd[i] = first ? init[i] : work_p0[i];
      t1  = opnd[7] + bsig1(opnd[4]) + ch(opnd[4], opnd[5], opnd[6]) + in9 + in8;
      t2  = bsig0(opnd[0]) + maj(opnd[0], opnd[1], opnd[2]);
      nxt = '{t1 + t2, opnd[0], opnd[1], opnd[2], opnd[3] + t1, opnd[4], opnd[5], opnd[6]};
   end

   // Stage p0: control FSM, working state and feed-forward shadow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_p0 <= IDLE;
         dly_p0   <= 8'd0;
         rnd_p0   <= 8'd0;
         ff_p0    <= 1'b0;
         done_p0  <= 1'b1;
         for (int i = 0; i < 8; i++) begin
            work_p0[i] <= '0;
            hash_p0[i] <= '0;
         end
      end else if (run) begin
         dly_p0   <= delay0;
         rnd_p0   <= 8'd0;
         ff_p0    <= feedfwd0;
         done_p0  <= 1'b0;
         state_p0 <= (delay0 != 8'd0) ? WAIT : ROUND;
      end else begin
         case (state_p0)
            WAIT: begin
               dly_p0 <= dly_p0 - 8'd1;
               if (dly_p0 == 8'd1) state_p0 <= ROUND;
            end
            ROUND: begin
               for (int i = 0; i < 8; i++) begin
                  work_p0[i] <= nxt[i];
                  if (first) hash_p0[i] <= init[i];
               end
               rnd_p0 <= rnd_p0 + 8'd1;
               if (rnd_p0 == LAST_RND) begin
                  if (ff_p0) begin
                     state_p0 <= FINAL;
                  end else begin
                     state_p0 <= IDLE;
                     done_p0  <= 1'b1;
                  end
               end
            end
            FINAL: begin
               for (int i = 0; i < 8; i++) work_p0[i] <= work_p0[i] + hash_p0[i];
               state_p0 <= IDLE;
               done_p0  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign out0 = work_p0[0];
   assign out1 = work_p0[1];
   assign out2 = work_p0[2];
   assign out3 = work_p0[3];
   assign out4 = work_p0[4];
   assign out5 = work_p0[5];
   assign out6 = work_p0[6];
   assign out7 = work_p0[7];
   assign done = done_p0;

endmodule

// File: doc/xunit_sha2_round.md
# xunit_sha2_round

Parametrised SHA-2 compression functional unit for the Versat datapath; it generalises the fixed SHA-256 round unit to 32-bit (SHA-224/256) and 64-bit (SHA-384/512) words. It performs a configurable number of rounds per `run`, consuming one message-schedule word and one round constant per cycle. It can optionally apply the final feed-forward addition of the initial hash state, so a complete block compression needs no extra adder units.

## Interface
- `DATA_W`, 32: word width; only 32 (SHA-256 rotations) and 64 (SHA-512 rotations) are legal.
- `ROUNDS`, 16: rounds per `run`, 1..255 (64 or 80 for a full block).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, asynchronous and active-high.
- `run`  in  1  single-cycle start pulse.
- `in0`..`in7`  in  DATA_W each  initial working state a..h.
- `in8`  in  DATA_W  message word W_t.
- `in9`  in  DATA_W  round constant K_t.
- `delay0`  in  8  config: idle cycles between `run` and the first round.
- `feedfwd0`  in  1  config: add the initial state to the result after the last round.
- `out0`..`out7`  out  DATA_W each  registered working state a..h.
- `done`  out  1  high when idle.

## Operation
- FSM states: IDLE, WAIT, ROUND, FINAL.
- IDLE, on `run`:
  - load the delay counter with `delay0`, clear the round counter, drop `done`;
  - go to WAIT if `delay0`≠0, else ROUND.
- WAIT: decrement the delay counter; go to ROUND when it reaches 0.
- ROUND, first cycle (round 0):
  - operand state is taken from `in0`..`in7`, not from the registers;
  - the same values are latched into a shadow register H.
- ROUND, later cycles: operand state is the registered `out0`..`out7`.
- Each ROUND cycle:
  - T1 = h + Σ1(e) + Ch(e,f,g) + `in9` + `in8`;
  - T2 = Σ0(a) + Maj(a,b,c);
  - new state = {T1+T2, a, b, c, d+T1, e, f, g};
  - all sums are modulo 2^DATA_W (carries discarded).
- Σ/Ch/Maj definitions:
  - DATA_W=32: Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - DATA_W=64: Σ0 = ROTR28^ROTR34^ROTR39; Σ1 = ROTR14^ROTR18^ROTR41.
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
- Last ROUND cycle: after round ROUNDS-1, go to FINAL if `feedfwd0`=1, else IDLE with `done`=1.
- FINAL (one cycle):
  - `out_i` ← `out_i` + H_i (mod 2^DATA_W), i = 0..7;
  - then IDLE, `done`=1.
- `delay0` and `feedfwd0` are sampled on `run` and held internally; later changes are ignored until the next `run`.
- `run` while busy (WAIT/ROUND/FINAL) aborts the current operation and restarts exactly as from IDLE.
- In IDLE, outputs hold their last value.

## Timing
- Reset values: `out0`..`out7` = 0, `done` = 1, state IDLE, all counters and H = 0. Reset applies immediately and asynchronously, including mid-operation.
- With `run` high in cycle T:
  - round r consumes `in8`/`in9` in cycle T+1+`delay0`+r;
  - its result is visible on the outputs from cycle T+2+`delay0`+r (one-cycle latency);
  - `in0`..`in7` must be valid in cycle T+1+`delay0` only.
- `done`:
  - falls in cycle T+1;
  - rises in cycle T+1+`delay0`+ROUNDS without feed-forward, or T+2+`delay0`+ROUNDS with feed-forward;
  - rises in the same cycle the final outputs appear.
- Throughput: one round per cycle with no bubbles; a new `run` may be issued in the cycle `done` rises.
- `delay0`=255 is legal and gives 255 WAIT cycles.
- ROUNDS=1: a single ROUND cycle, which is both the first and the last round.

## Test plan
- Reset mid-operation:
  - assert `rst` during ROUND;
  - outputs go to 0 and `done`=1 with no clock edge required;
  - after release, a `run` behaves normally.
- All-zero vector, DATA_W=32, ROUNDS=16, `delay0`=0, state, W and K all 0:
  - outputs stay 0 every cycle;
  - `done` rises at T+17.
- SHA-256 "abc" round 0:
  - state = 6A09E667, BB67AE85, 3C6EF372, A54FF53A, 510E527F, 9B05688C, 1F83D9AB, 5BE0CD19; W=61626380, K=428A2F98;
  - at T+2: out = 5D6AEBCD, 6A09E667, BB67AE85, 3C6EF372, FA2A4622, 510E527F, 9B05688C, 1F83D9AB.
- Full SHA-256 block, ROUNDS=64, `feedfwd0`=1, "abc" padded schedule:
  - out = BA7816BF 8F01CFEA 414140DE 5DAE2223 B00361A3 96177A9C B410FF61 F20015AD;
  - `done` at T+66.
- Delay and restart:
  - `delay0`=5: first output change occurs at T+7;
  - a second `run` at T+10 aborts and restarts, and results match a fresh `run`.
- DATA_W=64, ROUNDS=80, `feedfwd0`=1, SHA-512 "abc" block:
  - outputs match the golden-model digest (DDAF35A1…A54CA49F);
  - `done` at T+82.
